// File: rtl/usb_frame_packetizer.sv
// usb_frame_packetizer
//   Cuts a word stream into fixed PKT_WORDS-word packets for a USB bulk-IN
//   endpoint. Each packet holds PKT_WORDS-1 payload words followed by one
//   trailer word {seq, marker}. A partial packet is closed by flush_i or by
//   an idle timeout and is then filled with PAD_WORD up to the trailer.
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     s_data_i      input payload word        s_valid_i / s_ready_o  input handshake
//     flush_i       one-cycle request to close the current partial packet
//     m_data_o      output word               m_valid_o / m_ready_i  output handshake
//     m_last_o      high with the trailer word
//     stat_seq_o    sequence number carried by the next trailer
//     stat_pad_o    count of padded packets sent (saturating)
//
//   Handshakes: a word moves when valid and ready are both high at a rising
//   edge. Once m_valid_o is raised for a pad or trailer word, it stays high
//   and m_data_o stays stable until m_ready_i takes the word. In the payload
//   phase the path is a zero-latency pass-through, so m_valid_o follows
//   s_valid_i and s_ready_o follows m_ready_i.
module usb_frame_packetizer #(
    parameter int          DW        = 16,
    parameter int          PKT_WORDS = 256,
    parameter logic [7:0]  MARKER    = 8'hA0,
    parameter logic [15:0] PAD_WORD  = 16'h0,
    parameter int          TIMEOUT   = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic          flush_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    output logic          m_last_o,
    input  logic          m_ready_i,
    output logic [DW-9:0] stat_seq_o,
    output logic [15:0]   stat_pad_o
);

    localparam int SW = DW - 8;
    localparam int CW = $clog2(PKT_WORDS);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] IDLE_FIRE = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DW-1:0] PAD_EXT   = DW'(PAD_WORD);

    generate
        if (DW < 16) begin : g_dw_check
            $error("usb_frame_packetizer: DW must be at least 16");
        end
        if (PKT_WORDS < 2) begin : g_pkt_check
            $error("usb_frame_packetizer: PKT_WORDS must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_DATA  = 2'd0,
        MODE_PAD   = 2'd1,
        MODE_TRAIL = 2'd2
    } mode_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] seq_q, seq_d;
    logic          pad_q, pad_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [15:0]   stat_pad_q, stat_pad_d;

    mode_e mode;
    logic  beat;
    logic  timeout_hit;
    logic  flush_req;

    // Mode is a pure function of the registers. While rst is high the block
    // is forced to the pass-through mode so the outputs are defined before
    // the first reset edge has cleared the registers.
    always_comb begin
        mode = MODE_DATA;
        if (!rst) begin
            if (cnt_q == LAST_CNT) begin
                mode = MODE_TRAIL;
            end else if (pad_q) begin
                mode = MODE_PAD;
            end
        end
    end

    always_comb begin
        m_data_o  = s_data_i;
        m_valid_o = s_valid_i;
        s_ready_o = m_ready_i;
        m_last_o  = 1'b0;
        case (mode)
            MODE_PAD: begin
                m_data_o  = PAD_EXT;
                m_valid_o = 1'b1;
                s_ready_o = 1'b0;
            end
            MODE_TRAIL: begin
                m_data_o  = {seq_q, pad_q ? (MARKER | 8'h10) : MARKER};
                m_valid_o = 1'b1;
                s_ready_o = 1'b0;
                m_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign stat_seq_o = rst ? '0 : seq_q;
    assign stat_pad_o = rst ? '0 : stat_pad_q;

    assign beat        = m_valid_o & m_ready_i;
    assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_FIRE) && !s_valid_i;
    assign flush_req   = (mode == MODE_DATA) && (cnt_q != '0) && (flush_i || timeout_hit);

    always_comb begin
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        pad_d      = pad_q;
        idle_d     = idle_q;
        stat_pad_d = stat_pad_q;

        if (beat) begin
            if (mode == MODE_TRAIL) begin
                cnt_d = '0;
                pad_d = 1'b0;
                seq_d = seq_q + SW'(1);
                if (pad_q && stat_pad_q != 16'hFFFF) begin
                    stat_pad_d = stat_pad_q + 16'd1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A payload beat that fills the packet in the same cycle makes the
        // flush pointless: the normal trailer follows anyway.
        if (flush_req && !(beat && (cnt_q + CW'(1) == LAST_CNT))) begin
            pad_d = 1'b1;
        end

        if (s_valid_i || cnt_q == '0 || mode != MODE_DATA) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            seq_q      <= '0;
            pad_q      <= 1'b0;
            idle_q     <= '0;
            stat_pad_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            pad_q      <= pad_d;
            idle_q     <= idle_d;
            stat_pad_q <= stat_pad_d;
        end
    end

endmodule

// File: tb/tb_usb_frame_packetizer.sv
`timescale 1ns/1ps
module tb_usb_frame_packetizer;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          flush_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  logic          m_ready_i = 1'b1;
  logic [DW-9:0] stat_seq_o;
  logic [15:0]   stat_pad_o;

  usb_frame_packetizer #(
    .DW(DW), .PKT_WORDS(PW), .MARKER(8'hA0), .PAD_WORD(16'h0000), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .flush_i(flush_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .stat_seq_o(stat_seq_o), .stat_pad_o(stat_pad_o)
  );

  int n_checks = 0;
  int n_pass = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: the expected queue holds the pad/trailer words owed by
  // the packetizer ({last, data}); payload words pass straight through, so
  // an empty queue means the block is accepting payload.
  logic [16:0] exp_q[$];
  int          m_cnt = 0;    // payload words in the current packet
  int          m_run = 0;    // consecutive idle cycles inside a partial packet
  logic [7:0]  b_seq = '0;   // sequence number for the next trailer built
  logic [7:0]  m_seq = '0;   // trailers actually delivered
  logic [15:0] m_pad = '0;   // padded packets actually delivered

  always @(negedge clk) begin
    logic [16:0] head;
    int cnt_before;
    bit fire;
    if (rst) begin
      check("rst_valid", 32'(m_valid_o), 32'(s_valid_i));
      check("rst_ready", 32'(s_ready_o), 32'(m_ready_i));
      check("rst_last", 32'(m_last_o), 32'd0);
      check("rst_data", 32'(m_data_o), 32'(s_data_i));
      check("rst_seq", 32'(stat_seq_o), 32'd0);
      check("rst_pad", 32'(stat_pad_o), 32'd0);
      exp_q.delete();
      m_cnt = 0; m_run = 0; b_seq = '0; m_seq = '0; m_pad = '0;
    end else begin
      check("stat_seq", 32'(stat_seq_o), 32'(m_seq));
      check("stat_pad", 32'(stat_pad_o), 32'(m_pad));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("owed_valid", 32'(m_valid_o), 32'd1);
        check("owed_ready", 32'(s_ready_o), 32'd0);
        check("owed_data", 32'(m_data_o), 32'(head[15:0]));
        check("owed_last", 32'(m_last_o), 32'(head[16]));
        m_run = 0;
        if (m_ready_i) begin
          void'(exp_q.pop_front());
          if (head[16]) begin
            m_seq++;
            if (head[7:0] == 8'hB0 && m_pad != 16'hFFFF) m_pad++;
          end
        end
      end else begin
        check("pass_valid", 32'(m_valid_o), 32'(s_valid_i));
        check("pass_ready", 32'(s_ready_o), 32'(m_ready_i));
        check("pass_last", 32'(m_last_o), 32'd0);
        if (s_valid_i) check("pass_data", 32'(m_data_o), 32'(s_data_i));
        cnt_before = m_cnt;
        if (s_valid_i && m_ready_i) m_cnt++;
        if (!s_valid_i && cnt_before != 0) m_run++;
        else m_run = 0;
        fire = (m_run == TO);
        if (m_cnt == PW - 1) begin
          exp_q.push_back({1'b1, b_seq, 8'hA0});
          b_seq++;
          m_cnt = 0;
        end else if ((flush_i || fire) && cnt_before != 0) begin
          for (int i = m_cnt; i < PW - 1; i++) exp_q.push_back({1'b0, 16'h0000});
          exp_q.push_back({1'b1, b_seq, 8'hB0});
          b_seq++;
          m_cnt = 0;
          m_run = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [15:0] d, input bit fl);
    bit acc;
    acc = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = d;
    flush_i = fl;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      step();
    end
    s_valid_i = 1'b0;
    flush_i = 1'b0;
    check("word_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    s_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 16'($urandom);
    step();
    s_data_i = 16'($urandom);
    step();
    rst = 1'b0;
    s_valid_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ready_i = 1'b1;
    do_reset();

    // 1: three packets' worth of payload, ready always high
    for (int w = 1; w <= 21; w++) send_word(16'(w), 1'b0);
    check("t1_seq_before_trailer3", 32'(stat_seq_o), 32'd2);
    drain();
    check("t1_seq_end", 32'(stat_seq_o), 32'd3);

    // 2: explicit flush after three words
    do_reset();
    for (int w = 1; w <= 3; w++) send_word(16'(16'h100 + w), 1'b0);
    pulse_flush();
    drain();
    check("t2_stat_pad", 32'(stat_pad_o), 32'd1);
    check("t2_stat_seq", 32'(stat_seq_o), 32'd1);

    // 3: idle timeout closes a two-word packet; an empty packet never times out
    do_reset();
    send_word(16'h0201, 1'b0);
    send_word(16'h0202, 1'b0);
    idle_cycles(TO - 1);
    check("t3_no_pad_yet", 32'(m_valid_o), 32'd0);
    idle_cycles(1);
    check("t3_pad_started", 32'(m_valid_o), 32'd1);
    drain();
    check("t3_stat_pad", 32'(stat_pad_o), 32'd1);
    idle_cycles(100);
    check("t3_stat_seq_idle", 32'(stat_seq_o), 32'd1);

    // 4: random backpressure, data, gaps and flushes
    do_reset();
    rand_rdy = 1'b1;
    for (int w = 0; w < 60; w++) begin
      send_word(16'($urandom), 1'b0);
      if ($urandom_range(0, 5) == 0) pulse_flush();
      if ($urandom_range(0, 9) == 0) idle_cycles(TO + 4);
      else idle_cycles($urandom_range(0, 3));
    end
    drain();
    rand_rdy = 1'b0;
    m_ready_i = 1'b1;
    step();

    // 5: 256 full packets, sequence number wraps
    do_reset();
    for (int p = 0; p < 255; p++)
      for (int w = 0; w < PW - 1; w++) send_word(16'($urandom), 1'b0);
    drain();
    check("t5_seq_ff", 32'(stat_seq_o), 32'd255);
    for (int w = 0; w < PW - 1; w++) send_word(16'($urandom), 1'b0);
    drain();
    check("t5_seq_wrap", 32'(stat_seq_o), 32'd0);
    check("t5_stat_pad", 32'(stat_pad_o), 32'd0);

    // 6: reset mid-packet, then a clean packet with flush on its last word
    for (int w = 0; w < 5; w++) send_word(16'(16'h600 + w), 1'b0);
    do_reset();
    check("t6_seq_cleared", 32'(stat_seq_o), 32'd0);
    for (int w = 1; w <= 6; w++) send_word(16'(16'h610 + w), 1'b0);
    send_word(16'h0617, 1'b1);
    check("t6_trailer_last", 32'(m_last_o), 32'd1);
    check("t6_trailer_word", 32'(m_data_o), 32'h00A0);
    drain();
    check("t6_stat_seq", 32'(stat_seq_o), 32'd1);
    check("t6_stat_pad", 32'(stat_pad_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
